data_tlb_walker: RTL and testbench
==================================

DATA_TLB_WALKER -- requirements
Module: data_tlb_walker

Interface
REQ-001 SHALL have parameter TLB_ENTRIES, default 4, number of fully-associative TLB entries (power of 2, 2..16).
REQ-002 SHALL have parameter SV48_EN, default 1; 1 enables Sv48 (4-level) walks in addition to Sv39.
REQ-003 SHALL have port clk, input, 1, single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-low reset (0 = reset, sampled on clk rising edge).
REQ-005 SHALL have port mode, input, 2, current privilege level (U/S/M).
REQ-006 SHALL have port virAddr, input, 64, virtual address under translation.
REQ-007 SHALL have port satp, input, satp_t, mode and root PPN.
REQ-008 SHALL have port req_valid, input, 1, translation request; held stable with virAddr/req_store until resp_ok.
REQ-009 SHALL have port req_store, input, 1, 1 = store access, 0 = load.
REQ-010 SHALL have port sfence, input, 1, one-cycle pulse that flushes the whole TLB.
REQ-011 SHALL have port resp_ok, output, 1, one-cycle pulse marking the result as valid.
REQ-012 SHALL have port phyAddr, output, 64, translated physical address, valid with resp_ok.
REQ-013 SHALL have port page_fault, output, 1, valid with resp_ok; 1 = translation failed, phyAddr = 0.
REQ-014 SHALL have port dreq, output, dbus_req_t, PTE read request; strobe = 0, size = MSIZE8.
REQ-015 SHALL have port dresp, input, dbus_resp_t, PTE read response (data_ok, data).

Function
REQ-016 SHALL implement FSM states IDLE, WALK, RESP; a request is accepted only in IDLE, with req_valid=1, sfence=0, resp_ok=0.
REQ-017 SHALL treat mode==M_Mode or satp.mode==SATP_bare as pass-through: phyAddr=virAddr, page_fault=0, resp_ok one cycle after acceptance.
REQ-018 SHALL decode satp.mode 8 = Sv39 (3 levels) and 9 = Sv48 (4 levels, only if SV48_EN=1); any other non-bare mode, or 9 with SV48_EN=0, SHALL give page_fault one cycle after acceptance.
REQ-019 SHALL fault without a walk on a non-canonical address: bits 63:39 (Sv39) or 63:48 (Sv48) not all equal to bit 38 / 47.
REQ-020 SHALL look up the TLB combinationally on acceptance; each entry holds valid, VPN[35:0], PPN[43:0], level (0..3), and the R,W,X,U,A,D bits.
REQ-021 SHALL compare only VPN fields at or above the entry level (superpage match).
REQ-022 SHALL, on a TLB hit, apply the REQ-027 permission checks to the cached bits and assert resp_ok the next cycle.
REQ-023 SHALL, on a miss, enter WALK at the top level (2 or 3) with the base address taken from satp.ppn.
REQ-024 SHALL, in WALK, drive dreq.valid=1 with addr={8'b0, base_ppn, VPN[level], 3'b0} and hold it stable until dresp.data_ok.
REQ-025 SHALL deassert dreq.valid in the cycle after data_ok is sampled, and SHALL never have more than one outstanding read.
REQ-026 SHALL decode each PTE: V=0, or R=0 with W=1, is a fault; R|X=1 is a leaf; otherwise it is a pointer, so set base=PTE.ppn, decrement level, and issue the next read; a pointer at level 0 is a fault.
REQ-027 SHALL fault on a leaf when any of these hold: A=0; store with (W=0 or D=0); load with R=0; mode==U with U=0; mode==S with U=1; superpage with PPN bits below the level non-zero.
REQ-028 SHALL, for a good leaf at level L, form phyAddr as PTE.ppn above level L, VPN below level L, then virAddr[11:0], with bits 63:56 = 0.
REQ-029 SHALL, on a good leaf, install the entry at a round-robin pointer that advances modulo TLB_ENTRIES and wraps from TLB_ENTRIES-1 to 0; faulting PTEs SHALL NOT be installed.
REQ-030 SHALL go from WALK to RESP on a leaf or a fault; RESP drives resp_ok=1 for exactly one cycle and then returns to IDLE.
REQ-031 SHALL, on sfence, clear all valid bits at the next edge; sfence has priority over a same-cycle acceptance; sfence during WALK lets the walk finish but suppresses its install.
REQ-032 SHALL NOT update the TLB or FSM from dresp.data_ok while not in WALK.

Reset
REQ-033 SHALL, while reset=0 at a clk edge, force state=IDLE, resp_ok=0, page_fault=0, phyAddr=0, dreq.valid=0, all TLB valid bits=0 and the replacement pointer=0; reset mid-walk abandons the walk and any later data_ok is ignored.

Verification
REQ-034 SHALL cover: M_Mode, virAddr=0x8000_1234 -> resp_ok one cycle later, phyAddr=0x8000_1234, no dreq.
REQ-035 SHALL cover: Sv39, 3-level walk ending in a leaf PPN=0x80042 with A=D=R=W=1, S-mode store -> exactly 3 reads, phyAddr=0x8004_2xxx; repeating the request -> hit, resp_ok in 1 cycle, no dreq.
REQ-036 SHALL cover: level-1 leaf with PPN[8:0]=1 -> page_fault=1, no install; a level-1 leaf with PPN[8:0]=0 -> 2 MiB mapping where virAddr[20:0] passes through.
REQ-037 SHALL cover: load of a page with R=1, W=0, then store to it -> load OK, store page_fault=1 via the TLB hit path with no walk.
REQ-038 SHALL cover: fill TLB_ENTRIES+1 distinct pages -> entry 0 evicted (wrap); then sfence -> the next access walks again.
REQ-039 SHALL cover: reset=0 asserted during the second PTE read -> dreq.valid=0 next cycle; the late data_ok is ignored; the first request after reset walks from the root.

Source files
------------

// File: rtl/data_tlb_walker.sv
// rtl/data_tlb_walker.sv - data-side fully-associative TLB with Sv39/Sv48 page-table walker
// Flattened satp/dbus ports; PTE reads are single 8-byte loads, one outstanding at a time.
module data_tlb_walker #(
  parameter int TLB_ENTRIES = 4,
  parameter bit SV48_EN     = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  mode,
  input  logic [63:0] virAddr,
  input  logic [3:0]  satp_mode,
  input  logic [43:0] satp_ppn,
  input  logic        req_valid,
  input  logic        req_store,
  input  logic        sfence,
  output logic        resp_ok,
  output logic [63:0] phyAddr,
  output logic        page_fault,
  output logic        dreq_valid,
  output logic [63:0] dreq_addr,
  output logic [7:0]  dreq_strobe,
  output logic [2:0]  dreq_size,
  input  logic        dresp_data_ok,
  input  logic [63:0] dresp_data
);

  localparam int IDXW = (TLB_ENTRIES > 1) ? $clog2(TLB_ENTRIES) : 1;
  localparam logic [1:0] MODE_U = 2'd0;
  localparam logic [1:0] MODE_S = 2'd1;
  localparam logic [1:0] MODE_M = 2'd3;
  localparam logic [3:0] SATP_BARE = 4'd0;
  localparam logic [3:0] SATP_SV39 = 4'd8;
  localparam logic [3:0] SATP_SV48 = 4'd9;
  localparam logic [2:0] MSIZE8 = 3'd3;

  typedef enum logic [1:0] {IDLE, WALK, RESP} state_e;

  // Bits of a PPN/VPN that come from the virtual address for a leaf at level lvl.
  function automatic logic [43:0] lvl_mask(input logic [1:0] lvl);
    case (lvl)
      2'd0:    lvl_mask = 44'h0;
      2'd1:    lvl_mask = 44'h1FF;
      2'd2:    lvl_mask = 44'h3FFFF;
      default: lvl_mask = 44'h7FFFFFF;
    endcase
  endfunction

  // perm = {R, W, X, U, A, D}
  function automatic logic perm_fault(input logic [5:0] perm, input logic [1:0] lvl,
                                      input logic [43:0] ppn, input logic st,
                                      input logic [1:0] md);
    perm_fault = !perm[1] || (st && (!perm[4] || !perm[0])) || (!st && !perm[5]) ||
                 (md == MODE_U && !perm[2]) || (md == MODE_S && perm[2]) ||
                 ((ppn & lvl_mask(lvl)) != 44'h0);
  endfunction

  function automatic logic [63:0] form_pa(input logic [43:0] ppn, input logic [1:0] lvl,
                                          input logic [63:0] va);
    logic [43:0] m;
    m = lvl_mask(lvl);
    form_pa = {8'h0, (ppn & ~m) | ({8'h0, va[47:12]} & m), va[11:0]};
  endfunction

  state_e      state_q, state_d;
  logic [1:0]  level_q, level_d;
  logic [43:0] base_q, base_d;
  logic        gap_q, gap_d;
  logic        sfpend_q, sfpend_d;
  logic [63:0] phy_q, phy_d;
  logic        fault_q, fault_d;
  logic        install, leaf_fault;

  logic [TLB_ENTRIES-1:0] tv_q;
  logic [IDXW-1:0]        rr_q;
  logic [35:0]            tvpn_q  [TLB_ENTRIES];
  logic [43:0]            tppn_q  [TLB_ENTRIES];
  logic [1:0]             tlvl_q  [TLB_ENTRIES];
  logic [5:0]             tperm_q [TLB_ENTRIES];

  logic [35:0] vpn;
  logic        passthru, sv39, sv48, bad_mode, canon_ok;
  logic [1:0]  top_level;
  logic        hit;
  logic [IDXW-1:0] hit_idx;
  logic [43:0] hit_ppn;
  logic [1:0]  hit_lvl;
  logic [5:0]  hit_perm;
  logic [8:0]  walk_idx;

  logic        pte_v, pte_r, pte_w, pte_x;
  logic [5:0]  pte_perm;
  logic [43:0] pte_ppn;

  assign vpn       = virAddr[47:12];
  assign passthru  = (mode == MODE_M) || (satp_mode == SATP_BARE);
  assign sv39      = (satp_mode == SATP_SV39);
  assign sv48      = SV48_EN && (satp_mode == SATP_SV48);
  assign bad_mode  = !sv39 && !sv48;
  assign top_level = sv48 ? 2'd3 : 2'd2;
  assign canon_ok  = sv48 ? ((&virAddr[63:47]) || !(|virAddr[63:47]))
                          : ((&virAddr[63:38]) || !(|virAddr[63:38]));

  assign pte_v    = dresp_data[0];
  assign pte_r    = dresp_data[1];
  assign pte_w    = dresp_data[2];
  assign pte_x    = dresp_data[3];
  assign pte_perm = {dresp_data[1], dresp_data[2], dresp_data[3], dresp_data[4],
                     dresp_data[6], dresp_data[7]};
  assign pte_ppn  = dresp_data[53:10];

  // Superpage entries ignore the VPN fields below their level.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = TLB_ENTRIES - 1; i >= 0; i--) begin
      if (tv_q[i] && ((({8'h0, tvpn_q[i]} ^ {8'h0, vpn}) & ~lvl_mask(tlvl_q[i])) == 44'h0)) begin
        hit     = 1'b1;
        hit_idx = IDXW'(i);
      end
    end
  end

  assign hit_ppn  = tppn_q[hit_idx];
  assign hit_lvl  = tlvl_q[hit_idx];
  assign hit_perm = tperm_q[hit_idx];

  always_comb begin
    case (level_q)
      2'd0:    walk_idx = vpn[8:0];
      2'd1:    walk_idx = vpn[17:9];
      2'd2:    walk_idx = vpn[26:18];
      default: walk_idx = vpn[35:27];
    endcase
  end

  always_comb begin
    state_d    = state_q;
    level_d    = level_q;
    base_d     = base_q;
    gap_d      = 1'b0;
    sfpend_d   = sfpend_q;
    phy_d      = phy_q;
    fault_d    = fault_q;
    install    = 1'b0;
    leaf_fault = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid && !sfence) begin
          state_d = RESP;
          if (passthru) begin
            phy_d   = virAddr;
            fault_d = 1'b0;
          end else if (bad_mode || !canon_ok) begin
            phy_d   = '0;
            fault_d = 1'b1;
          end else if (hit) begin
            leaf_fault = perm_fault(hit_perm, hit_lvl, hit_ppn, req_store, mode);
            fault_d    = leaf_fault;
            phy_d      = leaf_fault ? 64'h0 : form_pa(hit_ppn, hit_lvl, virAddr);
          end else begin
            state_d  = WALK;
            level_d  = top_level;
            base_d   = satp_ppn;
            sfpend_d = 1'b0;
          end
        end
      end
      WALK: begin
        if (sfence) sfpend_d = 1'b1;
        // gap_q is the idle cycle between consecutive PTE reads.
        if (dresp_data_ok && !gap_q) begin
          if (!pte_v || (!pte_r && pte_w)) begin
            state_d = RESP;
            phy_d   = '0;
            fault_d = 1'b1;
          end else if (pte_r || pte_x) begin
            leaf_fault = perm_fault(pte_perm, level_q, pte_ppn, req_store, mode);
            state_d    = RESP;
            fault_d    = leaf_fault;
            phy_d      = leaf_fault ? 64'h0 : form_pa(pte_ppn, level_q, virAddr);
            install    = !leaf_fault && !sfence && !sfpend_q;
          end else if (level_q == 2'd0) begin
            state_d = RESP;
            phy_d   = '0;
            fault_d = 1'b1;
          end else begin
            base_d  = pte_ppn;
            level_d = level_q - 2'd1;
            gap_d   = 1'b1;
          end
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      level_q  <= '0;
      base_q   <= '0;
      gap_q    <= 1'b0;
      sfpend_q <= 1'b0;
      phy_q    <= '0;
      fault_q  <= 1'b0;
      tv_q     <= '0;
      rr_q     <= '0;
    end else begin
      state_q  <= state_d;
      level_q  <= level_d;
      base_q   <= base_d;
      gap_q    <= gap_d;
      sfpend_q <= sfpend_d;
      phy_q    <= phy_d;
      fault_q  <= fault_d;
      if (sfence) begin
        tv_q <= '0;
      end else if (install) begin
        tv_q[rr_q] <= 1'b1;
        rr_q       <= (rr_q == IDXW'(TLB_ENTRIES - 1)) ? '0 : rr_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (install) begin
      tvpn_q[rr_q]  <= vpn;
      tppn_q[rr_q]  <= pte_ppn;
      tlvl_q[rr_q]  <= level_q;
      tperm_q[rr_q] <= pte_perm;
    end
  end

  assign resp_ok     = (state_q == RESP);
  assign phyAddr     = phy_q;
  assign page_fault  = fault_q;
  assign dreq_valid  = (state_q == WALK) && !gap_q;
  assign dreq_addr   = {8'h0, base_q, walk_idx, 3'b000};
  assign dreq_strobe = 8'h0;
  assign dreq_size   = MSIZE8;

  logic unused_ok;
  assign unused_ok = ^{dresp_data[63:54], dresp_data[9:8], dresp_data[5], hit_perm[3]};

endmodule

// File: tb/tb_data_tlb_walker.sv
// tb/tb_data_tlb_walker.sv - scoreboard bench for data_tlb_walker with a PTE memory responder
module tb_data_tlb_walker;
  localparam int N = 4;
  localparam logic [7:0] FV = 8'h01, FR = 8'h02, FW = 8'h04, FA = 8'h40, FD = 8'h80;
  localparam logic [1:0] MU = 2'd0, MS = 2'd1, MM = 2'd3;
  localparam logic [63:0] VA_A = 64'h4040_3abc;
  localparam logic [63:0] VA_MIS = 64'h40A0_0123;
  localparam logic [63:0] VA_2M = 64'h40DA_BCDE;
  localparam logic [63:0] VA_RO = 64'h4040_4010;

  logic clk = 1'b0;
  logic reset;
  logic [1:0] mode;
  logic [63:0] virAddr;
  logic [3:0] satp_mode;
  logic [43:0] satp_ppn;
  logic req_valid, req_store, sfence;
  logic resp_ok, page_fault, dreq_valid;
  logic [63:0] phyAddr, dreq_addr;
  logic [7:0] dreq_strobe;
  logic [2:0] dreq_size;
  logic dresp_data_ok;
  logic [63:0] dresp_data;

  always #5 clk = ~clk;

  data_tlb_walker #(.TLB_ENTRIES(N), .SV48_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .mode(mode), .virAddr(virAddr), .satp_mode(satp_mode),
    .satp_ppn(satp_ppn), .req_valid(req_valid), .req_store(req_store), .sfence(sfence),
    .resp_ok(resp_ok), .phyAddr(phyAddr), .page_fault(page_fault), .dreq_valid(dreq_valid),
    .dreq_addr(dreq_addr), .dreq_strobe(dreq_strobe), .dreq_size(dreq_size),
    .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data)
  );

  typedef struct { logic [63:0] pa; logic pf; int reads; int lat; } exp_t;
  exp_t exp_q[$];
  exp_t e;
  logic [63:0] mem [logic [63:0]];
  logic [63:0] rd_log[$];
  int total = 0;
  int bad = 0;
  logic use_fixed = 1'b0;
  logic pending = 1'b0;
  logic [63:0] pend_addr;
  int cnt;
  logic [63:0] obs_pa;
  logic obs_pf, obs_to, obs_one;
  int obs_reads, obs_lat;

  function automatic logic [63:0] mk_pte(input logic [43:0] ppn, input logic [7:0] fl);
    return {10'h0, ppn, 2'b00, fl};
  endfunction

  function automatic logic [63:0] pte_at(input logic [43:0] base, input int idx);
    return {8'h0, base, idx[8:0], 3'b000};
  endfunction

  // Memory responder: latches one read, answers after 0..2 (or 3 when fixed) cycles.
  initial begin
    dresp_data_ok = 1'b0;
    dresp_data = '0;
    forever begin
      @(negedge clk);
      dresp_data_ok = 1'b0;
      if (pending) begin
        if (dreq_valid) begin
          total++;
          if (dreq_addr !== pend_addr) begin
            bad++;
            $display("FAIL dreq_hold addr=%h want=%h", dreq_addr, pend_addr);
          end
        end
        if (cnt == 0) begin
          dresp_data_ok = 1'b1;
          dresp_data = mem.exists(pend_addr) ? mem[pend_addr] : 64'h0;
          pending = 1'b0;
        end else cnt--;
      end else if (dreq_valid) begin
        pending = 1'b1;
        pend_addr = dreq_addr;
        rd_log.push_back(dreq_addr);
        cnt = use_fixed ? 3 : int'($urandom_range(0, 2));
      end
    end
  end

  task automatic drive_req(input logic [1:0] md, input logic [63:0] va, input logic st);
    int b;
    mode = md; virAddr = va; req_store = st; req_valid = 1'b1;
    b = rd_log.size(); obs_lat = 0; obs_to = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      obs_lat++;
      if (resp_ok) begin obs_to = 1'b0; break; end
    end
    obs_pa = phyAddr; obs_pf = page_fault; obs_reads = rd_log.size() - b;
    req_valid = 1'b0;
    @(posedge clk); #1;
    obs_one = !resp_ok;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic pulse_sfence();
    sfence = 1'b1;
    @(posedge clk); #1;
    sfence = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({resp_ok, page_fault, dreq_valid, phyAddr} !== 67'h0) begin
      bad++;
      $display("FAIL reset_state ok=%b pf=%b dv=%b pa=%h want all 0", resp_ok, page_fault, dreq_valid, phyAddr);
    end
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_passthru();
    logic [1:0] md [2] = '{MM, MS};
    logic [3:0] sm [2] = '{4'd8, 4'd0};
    logic [63:0] va [2] = '{64'h8000_1234, 64'h0012_3456_789a_bcde};
    for (int i = 0; i < 2; i++) begin
      satp_mode = sm[i];
      exp_q.push_back('{va[i], 1'b0, 0, 1});
      drive_req(md[i], va[i], 1'b0);
      e = exp_q.pop_front();
      total++;
      if (obs_to || !obs_one || obs_pa !== e.pa || obs_pf !== e.pf || obs_reads != e.reads || obs_lat != e.lat) begin
        bad++;
        $display("FAIL passthru%0d pa=%h pf=%b reads=%0d lat=%0d want pa=%h pf=0 reads=0 lat=1", i, obs_pa, obs_pf, obs_reads, obs_lat, e.pa);
      end
    end
  endtask

  task automatic test_fault_early();
    logic [3:0] sm [3] = '{4'd10, 4'd8, 4'd9};
    logic [63:0] va [3] = '{VA_A, 64'h0000_0080_0000_0000, 64'h0001_0000_0000_0000};
    for (int i = 0; i < 3; i++) begin
      satp_mode = sm[i];
      exp_q.push_back('{64'h0, 1'b1, 0, 1});
      drive_req(MS, va[i], 1'b0);
      e = exp_q.pop_front();
      total++;
      if (obs_to || obs_pa !== e.pa || obs_pf !== e.pf || obs_reads != e.reads || obs_lat != e.lat) begin
        bad++;
        $display("FAIL early_fault%0d pa=%h pf=%b reads=%0d lat=%0d want pa=0 pf=1 reads=0 lat=1", i, obs_pa, obs_pf, obs_reads, obs_lat);
      end
    end
    satp_mode = 4'd8;
  endtask

  // Store walk, repeat as hit, then U-mode load of the S page faults from the TLB.
  task automatic test_walk();
    logic [1:0] md [3] = '{MS, MS, MU};
    logic       st [3] = '{1'b1, 1'b1, 1'b0};
    exp_q.push_back('{64'h8004_2abc, 1'b0, 3, -1});
    exp_q.push_back('{64'h8004_2abc, 1'b0, 0, 1});
    exp_q.push_back('{64'h0, 1'b1, 0, 1});
    for (int i = 0; i < 3; i++) begin
      drive_req(md[i], VA_A, st[i]);
      e = exp_q.pop_front();
      total++;
      if (obs_to || !obs_one || obs_pa !== e.pa || obs_pf !== e.pf || obs_reads != e.reads ||
          (e.lat >= 0 && obs_lat != e.lat)) begin
        bad++;
        $display("FAIL walk%0d pa=%h pf=%b reads=%0d lat=%0d want pa=%h pf=%b reads=%0d", i, obs_pa, obs_pf, obs_reads, obs_lat, e.pa, e.pf, e.reads);
      end
    end
  endtask

  task automatic test_superpage();
    logic [63:0] va [4] = '{VA_MIS, VA_MIS, VA_2M, VA_2M};
    exp_q.push_back('{64'h0, 1'b1, 2, 0});
    exp_q.push_back('{64'h0, 1'b1, 2, 0});
    exp_q.push_back('{64'h803A_BCDE, 1'b0, 2, 0});
    exp_q.push_back('{64'h803A_BCDE, 1'b0, 0, 0});
    for (int i = 0; i < 4; i++) begin
      drive_req(MS, va[i], 1'b0);
      e = exp_q.pop_front();
      total++;
      if (obs_to || obs_pa !== e.pa || obs_pf !== e.pf || obs_reads != e.reads) begin
        bad++;
        $display("FAIL superpage%0d pa=%h pf=%b reads=%0d want pa=%h pf=%b reads=%0d", i, obs_pa, obs_pf, obs_reads, e.pa, e.pf, e.reads);
      end
    end
  endtask

  task automatic test_readonly();
    exp_q.push_back('{64'h8004_4010, 1'b0, 3, 0});
    exp_q.push_back('{64'h0, 1'b1, 0, 1});
    for (int i = 0; i < 2; i++) begin
      drive_req(MS, VA_RO, (i == 1));
      e = exp_q.pop_front();
      total++;
      if (obs_to || obs_pa !== e.pa || obs_pf !== e.pf || obs_reads != e.reads || (i == 1 && obs_lat != 1)) begin
        bad++;
        $display("FAIL readonly%0d pa=%h pf=%b reads=%0d lat=%0d want pa=%h pf=%b reads=%0d", i, obs_pa, obs_pf, obs_reads, obs_lat, e.pa, e.pf, e.reads);
      end
    end
  endtask

  // Pages 0..4 fill a 4-entry TLB from an empty state; page 4 overwrites entry 0.
  task automatic test_fill_sfence();
    int seq [8] = '{0, 1, 2, 3, 4, 1, 0, 2};
    int rds [8] = '{3, 3, 3, 3, 3, 0, 3, 3};
    do_reset();
    @(posedge clk); #1;
    for (int k = 0; k < 8; k++) begin
      logic [63:0] va, pa;
      int p;
      p = seq[k];
      va = 64'h4040_0000 | (64'(8 + p) << 12) | (64'(p) << 4);
      pa = (64'(44'h80100 + 44'(p)) << 12) | (64'(p) << 4);
      if (k == 7) pulse_sfence();
      exp_q.push_back('{pa, 1'b0, rds[k], 0});
      drive_req(MS, va, 1'b1);
      e = exp_q.pop_front();
      total++;
      if (obs_to || obs_pa !== e.pa || obs_pf !== e.pf || obs_reads != e.reads) begin
        bad++;
        $display("FAIL fill%0d pa=%h pf=%b reads=%0d want pa=%h pf=0 reads=%0d", k, obs_pa, obs_pf, obs_reads, e.pa, e.reads);
      end
    end
  endtask

  task automatic test_sv48();
    pulse_sfence();
    satp_mode = 4'd9; satp_ppn = 44'h90000;
    exp_q.push_back('{64'h8004_2abc, 1'b0, 4, 0});
    drive_req(MS, VA_A, 1'b1);
    e = exp_q.pop_front();
    total++;
    if (obs_to || obs_pa !== e.pa || obs_pf !== e.pf || obs_reads != e.reads) begin
      bad++;
      $display("FAIL sv48 pa=%h pf=%b reads=%0d want pa=%h pf=0 reads=4", obs_pa, obs_pf, obs_reads, e.pa);
    end
    satp_mode = 4'd8; satp_ppn = 44'h80000;
  endtask

  task automatic test_reset_midwalk();
    int b, seen;
    logic got;
    pulse_sfence();
    use_fixed = 1'b1;
    mode = MS; virAddr = VA_A; req_store = 1'b1; req_valid = 1'b1;
    b = rd_log.size(); got = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (rd_log.size() >= b + 2) begin got = 1'b1; break; end
    end
    reset = 1'b0; req_valid = 1'b0;
    @(posedge clk); #1;
    total++;
    if (!got || dreq_valid !== 1'b0 || resp_ok !== 1'b0) begin
      bad++;
      $display("FAIL reset_midwalk got_read2=%b dv=%b ok=%b want 1 0 0", got, dreq_valid, resp_ok);
    end
    reset = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (resp_ok !== 1'b0 || dreq_valid !== 1'b0) seen++;
    end
    total++;
    if (seen != 0 || pending) begin
      bad++;
      $display("FAIL late_data_ok busy_cycles=%0d pending=%b want 0 0", seen, pending);
    end
    use_fixed = 1'b0;
    b = rd_log.size();
    exp_q.push_back('{64'h8004_2abc, 1'b0, 3, 0});
    drive_req(MS, VA_A, 1'b1);
    e = exp_q.pop_front();
    total++;
    if (obs_to || obs_pa !== e.pa || obs_pf !== e.pf || obs_reads != e.reads || rd_log[b] !== 64'h8000_0008) begin
      bad++;
      $display("FAIL rewalk pa=%h pf=%b reads=%0d first=%h want pa=%h reads=3 first=80000008", obs_pa, obs_pf, obs_reads, rd_log[b], e.pa);
    end
  endtask

  initial begin
    mode = MS; virAddr = '0; satp_mode = 4'd8; satp_ppn = 44'h80000;
    req_valid = 1'b0; req_store = 1'b0; sfence = 1'b0; reset = 1'b0;
    mem[pte_at(44'h80000, 1)] = mk_pte(44'h80001, FV);
    mem[pte_at(44'h80001, 2)] = mk_pte(44'h80002, FV);
    mem[pte_at(44'h80001, 5)] = mk_pte(44'h80201, FV | FR | FW | FA | FD);
    mem[pte_at(44'h80001, 6)] = mk_pte(44'h80200, FV | FR | FW | FA | FD);
    mem[pte_at(44'h80002, 3)] = mk_pte(44'h80042, FV | FR | FW | FA | FD);
    mem[pte_at(44'h80002, 4)] = mk_pte(44'h80044, FV | FR | FA);
    for (int p = 0; p < 5; p++)
      mem[pte_at(44'h80002, 8 + p)] = mk_pte(44'h80100 + 44'(p), FV | FR | FW | FA | FD);
    mem[pte_at(44'h90000, 0)] = mk_pte(44'h80000, FV);

    test_reset();
    test_passthru();
    test_fault_early();
    test_walk();
    test_superpage();
    test_readonly();
    test_fill_sfence();
    test_sv48();
    test_reset_midwalk();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
